// File: rtl/cic_decim_ctrl.sv
// Sequencer for the CIC decimation datapath.
// Accepts samples on a valid/ready handshake, drives the filter input and
// clock enable, follows each block's result through a tag pipe that advances
// with the filter, and stores the decimated results in a small output FIFO.
// Credit-based admission ensures that the FIFO cannot overflow.
// Optional feature macro: CIC_CTRL_STATS_EN adds the out_cnt and stall_cnt ports.
module cic_decim_ctrl #(
    parameter int WIDTH      = 8,
    parameter int RATE       = 4,
    parameter int LATENCY    = 5,
    parameter int DISCARD    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             f_clr,
    output logic             f_en,
    output logic [WIDTH-1:0] f_in,
    input  logic [WIDTH-1:0] f_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
`ifdef CIC_CTRL_STATS_EN
    output logic [15:0]      out_cnt,
    output logic [15:0]      stall_cnt,
`endif
    output logic             busy
);
    localparam int PW = $clog2(RATE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1) + 1;
    localparam int DW = $clog2(DISCARD + 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state, state_nx;
    logic [PW-1:0]    phase;
    logic [LATENCY-1:0] tag_pipe;
    logic [CW-1:0]    inflight, fifo_cnt, used;
    logic [DW-1:0]    disc_cnt;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             last_phase, credit_ok, accept, inject, tag_exit, push, pop, go;

    assign last_phase = (phase == PW'(RATE - 1));
    assign used       = fifo_cnt + inflight;
    // A pop in the current cycle is ignored here, so this check is conservative.
    assign credit_ok  = (used < CW'(FIFO_DEPTH));
    assign accept     = s_valid & s_ready;
    assign inject     = accept & last_phase;
    assign tag_exit   = f_en & tag_pipe[LATENCY-1];
    assign push       = tag_exit & (disc_cnt == '0);
    assign pop        = m_valid & m_ready;
    assign go         = (state == IDLE) & start;
    assign m_valid    = (fifo_cnt != '0);
    assign m_data     = m_valid ? mem[rd_ptr] : '0;
    assign busy       = (state != IDLE);

    // Next-state logic and filter/handshake controls
    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        f_en     = 1'b0;
        f_in     = '0;
        f_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    f_clr    = 1'b1;
                end
            end
            RUN: begin
                s_ready = credit_ok | ~last_phase;
                if (s_valid & s_ready) begin
                    f_en = 1'b1;
                    f_in = s_data;
                end
                if (stop) state_nx = DRAIN;
            end
            DRAIN: begin
                // Every in-flight tag already holds a reserved FIFO slot, because it
                // was admitted only with credit. Flushing therefore needs no new
                // credit. Waiting for spare credit would deadlock when reservations
                // fill the FIFO.
                if (inflight == '0)
                    state_nx = IDLE;
                else if (used <= CW'(FIFO_DEPTH))
                    f_en = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Decimation phase. On stop the phase is cleared, so a partial block is dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                          phase <= '0;
        else if (go)                        phase <= '0;
        else if (state == RUN && stop)      phase <= '0;
        else if (accept)                    phase <= phase + 1'b1;
    end

    // Tag pipe advances with filter enables. Latency is counted in enables, not in clocks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_pipe <= '0;
            inflight <= '0;
        end else if (go) begin
            tag_pipe <= '0;
            inflight <= '0;
        end else begin
            if (f_en) tag_pipe <= {tag_pipe[LATENCY-2:0], inject};
            inflight <= inflight + CW'(inject) - CW'(tag_exit);
        end
    end

    // Transient discard counter, reloaded on each start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                             disc_cnt <= '0;
        else if (go)                           disc_cnt <= DW'(DISCARD);
        else if (tag_exit && disc_cnt != '0)   disc_cnt <= disc_cnt - 1'b1;
    end

    // FIFO pointers and occupancy. The FIFO keeps draining after the run ends.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= f_out;
    end

`ifdef CIC_CTRL_STATS_EN
    // Saturating statistics counters, cleared on reset and on each start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_cnt   <= '0;
            stall_cnt <= '0;
        end else if (go) begin
            out_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop && out_cnt != 16'hFFFF) out_cnt <= out_cnt + 1'b1;
            if (state == RUN && s_valid && !s_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Bench for cic_decim_ctrl.
// It uses two instances: d0 with FIFO_DEPTH=4 and DISCARD=1, and d1 with
// FIFO_DEPTH=2 and DISCARD=0. Each instance drives a filter stub whose f_out is
// f_in delayed by 5 enables.
module tb_cic_decim_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic [1:0]      start, stop, s_valid, s_ready, f_clr, f_en, m_valid, m_ready, busy;
    logic [1:0][7:0] s_data, f_in, f_out, m_data;
`ifdef CIC_CTRL_STATS_EN
    logic [1:0][15:0] out_cnt, stall_cnt;
`endif

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : gd
            logic [4:0][7:0] dl;
            cic_decim_ctrl #(.WIDTH(8), .RATE(4), .LATENCY(5),
                             .DISCARD(g == 0 ? 1 : 0), .FIFO_DEPTH(g == 0 ? 4 : 2)) u_dut (
                .clk(clk), .rstn(rstn), .start(start[g]), .stop(stop[g]),
                .s_valid(s_valid[g]), .s_ready(s_ready[g]), .s_data(s_data[g]),
                .f_clr(f_clr[g]), .f_en(f_en[g]), .f_in(f_in[g]), .f_out(f_out[g]),
                .m_valid(m_valid[g]), .m_ready(m_ready[g]), .m_data(m_data[g]),
`ifdef CIC_CTRL_STATS_EN
                .out_cnt(out_cnt[g]), .stall_cnt(stall_cnt[g]),
`endif
                .busy(busy[g]));
            always @(posedge clk or negedge rstn) begin
                if (!rstn)         dl <= '0;
                else if (f_clr[g]) dl <= '0;
                else if (f_en[g])  dl <= {dl[3:0], f_in[g]};
            end
            assign f_out[g] = dl[4];
        end
    endgenerate

    int pass_n = 0, total_n = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor for the selected instance. It only appends to its logs.
    int cur = 0;
    byte unsigned outq[$], accq[$], refq[$];
    int flush_n = 0, flush_bad = 0, clr_n = 0;
    always @(negedge clk) begin
        if (rstn) begin
            if (m_valid[cur] && m_ready[cur]) outq.push_back(m_data[cur]);
            if (f_en[cur] && s_ready[cur])    accq.push_back(f_in[cur]);
            if (f_en[cur] && !s_ready[cur]) begin
                flush_n++;
                if (f_in[cur] != 8'd0) flush_bad++;
            end
            if (s_valid[cur] && !s_ready[cur] && busy[cur]) refq.push_back(s_data[cur]);
            if (f_clr[cur]) clr_n++;
        end
    end

    // mode: 0 = m_ready is held high; 1 = m_ready toggles every cycle;
    // 2 = m_ready is held low until 10 cycles after the first refusal.
    typedef struct {
        int dut; int n; int mode; int exp_n; int exp[4]; int exp_flush; int exp_ref;
    } row_t;
    row_t rows[4];

    function automatic row_t mk(int dut, int n, int mode, int e0, int e1, int e2, int e3,
                                int en, int fl, int rf);
        row_t r;
        r.dut = dut; r.n = n; r.mode = mode; r.exp_n = en;
        r.exp[0] = e0; r.exp[1] = e1; r.exp[2] = e2; r.exp[3] = e3;
        r.exp_flush = fl; r.exp_ref = rf;
        return r;
    endfunction

    // Pulse start, feed samples 1..n, then pulse stop after the last accept.
    task automatic feed_run(input int n);
        bit ok;
        @(posedge clk); #1 start[cur] = 1'b1;
        @(posedge clk); #1 start[cur] = 1'b0;
        for (int k = 1; k <= n; k++) begin
            s_valid[cur] = 1'b1; s_data[cur] = 8'(k); ok = 1'b0;
            for (int w = 0; w < 300 && !ok; w++) begin
                @(negedge clk); ok = s_ready[cur];
                @(posedge clk); #1;
            end
            if (!ok) begin chk("feed_timeout", k, 0); break; end
        end
        s_valid[cur] = 1'b0; stop[cur] = 1'b1;
        @(posedge clk); #1 stop[cur] = 1'b0;
    endtask

    task automatic run_row(input row_t t);
        int ob, ab, fb, fbb, rb, cb, bad, hold;
        bit done;
        cur = t.dut;
        @(negedge clk);
        ob = outq.size(); ab = accq.size(); rb = refq.size();
        fb = flush_n; fbb = flush_bad; cb = clr_n;
        m_ready[cur] = (t.mode == 0);
        done = 1'b0; hold = 0;
        fork
            begin
                feed_run(t.n);
                for (int w = 0; w < 400 && busy[cur]; w++) @(negedge clk);
                chk("busy_after_drain", busy[cur], 0);
                for (int w = 0; w < 400 && m_valid[cur]; w++) @(negedge clk);
                chk("fifo_empty", m_valid[cur], 0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    if (t.mode == 1) m_ready[cur] = ~m_ready[cur];
                    else if (t.mode == 2 && refq.size() > rb) begin
                        if (hold >= 10) m_ready[cur] = 1'b1;
                        else hold++;
                    end
                end
            end
        join
        chk("out_count", outq.size() - ob, t.exp_n);
        for (int i = 0; i < t.exp_n && ob + i < outq.size(); i++)
            chk($sformatf("out_data[%0d]", i), outq[ob + i], t.exp[i]);
        chk("accepted", accq.size() - ab, t.n);
        bad = 0;
        for (int i = 0; i < t.n && ab + i < accq.size(); i++)
            if (accq[ab + i] != 8'(i + 1)) bad++;
        chk("accept_order_errs", bad, 0);
        chk("flush_enables", flush_n - fb, t.exp_flush);
        chk("flush_nonzero_fin", flush_bad - fbb, 0);
        chk("f_clr_pulses", clr_n - cb, 1);
        if (t.exp_ref == 0) chk("refusals", refq.size() - rb, 0);
        else chk("first_refused", (refq.size() > rb) ? int'(refq[rb]) : -1, t.exp_ref);
`ifdef CIC_CTRL_STATS_EN
        chk("out_cnt", out_cnt[cur], t.exp_n);
        chk("stall_cnt", stall_cnt[cur], refq.size() - rb);
`endif
    endtask

    initial begin
        int ob;
        rows[0] = mk(0, 16, 0, 8, 12, 16, 0, 3, 5, 0);   // sample 4 is discarded as transient
        rows[1] = mk(1, 6, 0, 4, 0, 0, 0, 1, 3, 0);      // samples 5 and 6 are dropped; 2 accepts plus 3 flushes
        rows[2] = mk(1, 16, 2, 4, 8, 12, 16, 4, 5, 12);  // the credit stall holds sample 12
        rows[3] = mk(0, 16, 1, 8, 12, 16, 0, 3, 5, 0);   // m_ready toggles

        rstn = 1'b0; start = '0; stop = '0; s_valid = '0; s_data = '0; m_ready = '0;
        #3;
        chk("rst_s_ready", s_ready, 0); chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0); chk("rst_f_en", f_en, 0);
        chk("rst_f_clr", f_clr, 0); chk("rst_f_in", f_in, 0); chk("rst_m_data", m_data, 0);
        #9 rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_s_ready", s_ready, 0); chk("post_rst_busy", busy, 0);

        for (int r = 0; r < 4; r++) run_row(rows[r]);

        // Reset during DRAIN while the FIFO holds 8 and 12
        cur = 0; m_ready[0] = 1'b0;
        ob = flush_n;
        feed_run(16);
        for (int w = 0; w < 100 && flush_n - ob < 2; w++) @(negedge clk);
        @(posedge clk); #2;
        chk("pre_rst_busy", busy[0], 1);
        chk("pre_rst_m_valid", m_valid[0], 1);
        chk("pre_rst_head", m_data[0], 8);
        #1 rstn = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid[0], 0); chk("midrst_busy", busy[0], 0);
        chk("midrst_f_en", f_en[0], 0); chk("midrst_m_data", m_data[0], 0);
        @(negedge clk); #2 rstn = 1'b1;
        m_ready[0] = 1'b1;
        ob = outq.size();
        repeat (10) @(posedge clk);
        #1;
        chk("postrst_s_ready", s_ready[0], 0);
        chk("postrst_busy", busy[0], 0);
        chk("postrst_no_output", outq.size() - ob, 0);

        // A fresh run after the abort behaves like the first run
        run_row(rows[0]);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
